vga_timing_checker: RTL and testbench
=====================================

// Module: vga_timing_checker
// PURPOSE
// Synthesisable, parametrised VGA sync monitor. It checks the hsync/vsync outputs of the
// display pipeline against a nominal mode, counts frames and asserts done after N_FRAMES.
// It replaces the fixed two-vsync-edge wait in simulation. It also sits on-chip as a debug
// probe beside the VGA output (err_any can drive an LED).
// PARAMETERS
// H_TOTAL          1056  pixels per line incl. blanking
// H_SYNC           128   hsync pulse width, pixels
// V_TOTAL          628   lines per frame
// V_SYNC           4     vsync pulse width, lines
// CLK_PER_PIX      1     clk cycles per pixel; expected line period = H_TOTAL*CLK_PER_PIX
// SYNC_ACTIVE_LOW  1     1: sync asserted when low; 0: asserted when high
// N_FRAMES         2     frames to observe before done
// CNT_W            24    width of the clk-cycle counters (saturating)
// PORTS
// clk          in   1      system clock
// rst          in   1      asynchronous, active-high reset
// hsync        in   1      horizontal sync under test
// vsync        in   1      vertical sync under test
// done         out  1      N_FRAMES frames observed; sticky
// frame_cnt    out  8      frames counted since arming
// err_hper     out  1      sticky: line period != H_TOTAL*CLK_PER_PIX
// err_hwid     out  1      sticky: hsync width != H_SYNC*CLK_PER_PIX
// err_vper     out  1      sticky: lines per frame != V_TOTAL
// err_vwid     out  1      sticky: vsync width (in lines) != V_SYNC
// err_timeout  out  1      sticky: no hsync assertion within 2*H_TOTAL*CLK_PER_PIX clks
// err_any      out  1      OR of all err_* flags
// err_frame    out  8      frame_cnt value when the first error was set
// last_hper    out  CNT_W  most recent measured line period, clk cycles
// BEHAVIOUR
// - Reset (async, any time incl. mid-frame): all outputs 0, all counters 0, state IDLE.
// - Inputs pass through one register stage.
// - Asserted levels: hs_a = hsync ^ SYNC_ACTIVE_LOW, vs_a likewise.
// - Edge detect: an assert edge is 0->1 of hs_a/vs_a; a deassert edge is 1->0.
// - Edge detection adds 2 clk cycles of latency from a pin change to any flag/counter update.
// - FSM:
//   - IDLE: wait for the first hs assert edge, then go to HSYNCED. Horizontal checks are armed
//     from here.
//   - HSYNCED: wait for the first vs assert edge, then go to RUN. Vertical checks are armed and
//     frame_cnt=0. Partial first frame/line never flags.
//   - RUN: on each later vs assert edge, frame_cnt+=1.
//     - When frame_cnt reaches N_FRAMES, go to DONE.
//   - DONE: done=1. Counters, frame_cnt, last_hper and err_* freeze until rst.
// - Line period = clk cycles between consecutive hs assert edges. It is loaded into last_hper
//   and compared on every edge after the first.
// - hsync width = clk cycles hs_a is high, compared at the deassert edge.
// - Lines per frame = hs assert edges from one vs assert edge (inclusive) to the next
//   (exclusive). An hs edge in the same cycle as a vs edge counts as line 1 of the new frame.
// - vsync width = hs assert edges while vs_a=1, including a coincident one at the vs assert edge.
// - Timeout counter: cleared on each hs assert edge. On reaching 2*H_TOTAL*CLK_PER_PIX in
//   HSYNCED/RUN it sets err_timeout once and saturates.
// - All clk counters saturate at 2^CNT_W-1. A saturated period always mismatches.
// - Error flags are sticky.
//   - err_frame is captured only on the 0->1 transition of err_any.
//   - Several errors in one cycle all set; err_frame is captured once.
//   - Errors also set in HSYNCED (frame_cnt=0).
// - frame_cnt wraps 255->0 only if N_FRAMES>255 (do not set this).
// TESTING
// (bench params: H_TOTAL=20 H_SYNC=4 V_TOTAL=10 V_SYNC=2 CLK_PER_PIX=1 N_FRAMES=2, active-low)
// 1 Nominal: ideal 20-clk lines, 10-line frames -> done=1 after 2nd vs edge post-arming,
//   frame_cnt=2, err_any=0, last_hper=20.
// 2 One line 21 clks in frame 1 -> err_hper=1, err_frame=1, other err_*=0, done still asserts.
// 3 hsync pulse 5 clks -> err_hwid=1.
//   Separately, an 11-line frame -> err_vper=1.
//   Separately, a 3-line vsync -> err_vwid=1.
// 4 hsync held high (deasserted) after arming -> err_timeout=1 exactly 40 clks after the last
//   hs edge, no done.
// 5 rst pulsed mid-frame 1 -> all outputs 0 within same cycle.
//   After that, a fresh partial frame raises no errors and done follows 2 full frames.
// 6 SYNC_ACTIVE_LOW=0, inverted stimulus of case 1 -> identical results to case 1.

Source files
------------

// File: rtl/vga_timing_checker.sv
// VGA sync monitor: measures hsync/vsync timing against a nominal mode, flags sticky
// errors, counts frames and raises done after N_FRAMES.
module vga_timing_checker #(
  parameter int unsigned H_TOTAL         = 1056,
  parameter int unsigned H_SYNC          = 128,
  parameter int unsigned V_TOTAL         = 628,
  parameter int unsigned V_SYNC          = 4,
  parameter int unsigned CLK_PER_PIX     = 1,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned N_FRAMES        = 2,
  parameter int unsigned CNT_W           = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  output logic             done,
  output logic [7:0]       frame_cnt,
  output logic             err_hper,
  output logic             err_hwid,
  output logic             err_vper,
  output logic             err_vwid,
  output logic             err_timeout,
  output logic             err_any,
  output logic [7:0]       err_frame,
  output logic [CNT_W-1:0] last_hper
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HPER_EXP = CNT_W'(H_TOTAL * CLK_PER_PIX);
  localparam logic [CNT_W-1:0] HWID_EXP = CNT_W'(H_SYNC * CLK_PER_PIX);
  localparam logic [CNT_W-1:0] VPER_EXP = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] VWID_EXP = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] TOUT     = CNT_W'(2 * H_TOTAL * CLK_PER_PIX);
  localparam logic [7:0]       FRM_EXP  = 8'(N_FRAMES);

  typedef enum logic [1:0] {StIdle, StHsynced, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             hs_s, vs_s, hs_d, vs_d;
  logic [CNT_W-1:0] hper_cnt_q, hper_cnt_d;
  logic [CNT_W-1:0] hwid_cnt_q, hwid_cnt_d;
  logic [CNT_W-1:0] vline_q, vline_d;
  logic [CNT_W-1:0] vwid_q, vwid_d;
  logic [CNT_W-1:0] last_hper_q, last_hper_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]       err_frame_q, err_frame_d;
  logic             err_hper_q, err_hwid_q, err_vper_q, err_vwid_q, err_tout_q;
  logic             err_hper_d, err_hwid_d, err_vper_d, err_vwid_d, err_tout_d;
  logic             hs_rise, hs_fall, vs_rise, vs_fall, h_armed, v_armed;
  logic             set_hper, set_hwid, set_vper, set_vwid, set_tout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_ONE;
  endfunction

  assign hs_rise = hs_s & ~hs_d;
  assign hs_fall = ~hs_s & hs_d;
  assign vs_rise = vs_s & ~vs_d;
  assign vs_fall = ~vs_s & vs_d;
  assign h_armed = (state_q == StHsynced) || (state_q == StRun);
  assign v_armed = (state_q == StRun);

  always_comb begin
    state_d     = state_q;
    hper_cnt_d  = hper_cnt_q;
    hwid_cnt_d  = hwid_cnt_q;
    vline_d     = vline_q;
    vwid_d      = vwid_q;
    last_hper_d = last_hper_q;
    frame_cnt_d = frame_cnt_q;
    err_frame_d = err_frame_q;
    set_hper    = 1'b0;
    set_hwid    = 1'b0;
    set_vper    = 1'b0;
    set_vwid    = 1'b0;
    set_tout    = 1'b0;

    if (state_q != StDone) begin
      hper_cnt_d = hs_rise ? CNT_ONE : sat_inc(hper_cnt_q);
      if (hs_rise) begin
        hwid_cnt_d = CNT_ONE;
      end else if (hs_s) begin
        hwid_cnt_d = sat_inc(hwid_cnt_q);
      end
      // A coincident hs edge is line 1 of the new frame and part of the vsync pulse.
      if (vs_rise) begin
        vline_d = hs_rise ? CNT_ONE : '0;
        vwid_d  = hs_rise ? CNT_ONE : '0;
      end else if (hs_rise) begin
        vline_d = sat_inc(vline_q);
        if (vs_s) vwid_d = sat_inc(vwid_q);
      end

      if (h_armed && hs_rise) begin
        last_hper_d = hper_cnt_q;
        set_hper    = (hper_cnt_q == CNT_MAX) || (hper_cnt_q != HPER_EXP);
      end
      set_hwid = h_armed && hs_fall && ((hwid_cnt_q == CNT_MAX) || (hwid_cnt_q != HWID_EXP));
      set_tout = h_armed && (hper_cnt_d == TOUT) && (hper_cnt_q != TOUT);
      set_vper = v_armed && vs_rise && ((vline_q == CNT_MAX) || (vline_q != VPER_EXP));
      set_vwid = v_armed && vs_fall && ((vwid_q == CNT_MAX) || (vwid_q != VWID_EXP));

      unique case (state_q)
        StIdle:    if (hs_rise) state_d = StHsynced;
        StHsynced: begin
          if (vs_rise) begin
            state_d     = StRun;
            frame_cnt_d = '0;
          end
        end
        StRun: begin
          if (vs_rise) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (frame_cnt_d == FRM_EXP) state_d = StDone;
          end
        end
        default: state_d = state_q;
      endcase

      if (!err_any && (set_hper || set_hwid || set_vper || set_vwid || set_tout)) begin
        err_frame_d = frame_cnt_q;
      end
    end

    err_hper_d = err_hper_q | set_hper;
    err_hwid_d = err_hwid_q | set_hwid;
    err_vper_d = err_vper_q | set_vper;
    err_vwid_d = err_vwid_q | set_vwid;
    err_tout_d = err_tout_q | set_tout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hs_s        <= 1'b0;
      vs_s        <= 1'b0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      hper_cnt_q  <= '0;
      hwid_cnt_q  <= '0;
      vline_q     <= '0;
      vwid_q      <= '0;
      last_hper_q <= '0;
      frame_cnt_q <= '0;
      err_frame_q <= '0;
      err_hper_q  <= 1'b0;
      err_hwid_q  <= 1'b0;
      err_vper_q  <= 1'b0;
      err_vwid_q  <= 1'b0;
      err_tout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_s        <= hsync ^ SYNC_ACTIVE_LOW;
      vs_s        <= vsync ^ SYNC_ACTIVE_LOW;
      hs_d        <= hs_s;
      vs_d        <= vs_s;
      hper_cnt_q  <= hper_cnt_d;
      hwid_cnt_q  <= hwid_cnt_d;
      vline_q     <= vline_d;
      vwid_q      <= vwid_d;
      last_hper_q <= last_hper_d;
      frame_cnt_q <= frame_cnt_d;
      err_frame_q <= err_frame_d;
      err_hper_q  <= err_hper_d;
      err_hwid_q  <= err_hwid_d;
      err_vper_q  <= err_vper_d;
      err_vwid_q  <= err_vwid_d;
      err_tout_q  <= err_tout_d;
    end
  end

  assign done        = (state_q == StDone);
  assign frame_cnt   = frame_cnt_q;
  assign err_hper    = err_hper_q;
  assign err_hwid    = err_hwid_q;
  assign err_vper    = err_vper_q;
  assign err_vwid    = err_vwid_q;
  assign err_timeout = err_tout_q;
  assign err_any     = err_hper_q | err_hwid_q | err_vper_q | err_vwid_q | err_tout_q;
  assign err_frame   = err_frame_q;
  assign last_hper   = last_hper_q;

endmodule

// File: tb/tb_vga_timing_checker.sv
// Directed bench for vga_timing_checker in a 20x10 toy mode; an active-high instance
// receives the inverted pins and must give the same results.
module tb_vga_timing_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs_as = 1'b0;
  logic vs_as = 1'b0;
  logic hsync_l, vsync_l;
  int   n_checks = 0;
  int   n_pass = 0;

  assign hsync_l = ~hs_as;
  assign vsync_l = ~vs_as;

  always #5 clk = ~clk;

  logic        done, err_hper, err_hwid, err_vper, err_vwid, err_timeout, err_any;
  logic [7:0]  frame_cnt, err_frame;
  logic [23:0] last_hper;
  logic        done_h, err_hper_h, err_hwid_h, err_vper_h, err_vwid_h, err_timeout_h, err_any_h;
  logic [7:0]  frame_cnt_h, err_frame_h;
  logic [23:0] last_hper_h;

  vga_timing_checker #(
    .H_TOTAL(20), .H_SYNC(4), .V_TOTAL(10), .V_SYNC(2), .CLK_PER_PIX(1),
    .SYNC_ACTIVE_LOW(1'b1), .N_FRAMES(2), .CNT_W(24)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync_l), .vsync(vsync_l),
    .done(done), .frame_cnt(frame_cnt), .err_hper(err_hper), .err_hwid(err_hwid),
    .err_vper(err_vper), .err_vwid(err_vwid), .err_timeout(err_timeout),
    .err_any(err_any), .err_frame(err_frame), .last_hper(last_hper)
  );

  vga_timing_checker #(
    .H_TOTAL(20), .H_SYNC(4), .V_TOTAL(10), .V_SYNC(2), .CLK_PER_PIX(1),
    .SYNC_ACTIVE_LOW(1'b0), .N_FRAMES(2), .CNT_W(24)
  ) dut_h (
    .clk(clk), .rst(rst), .hsync(hs_as), .vsync(vs_as),
    .done(done_h), .frame_cnt(frame_cnt_h), .err_hper(err_hper_h), .err_hwid(err_hwid_h),
    .err_vper(err_vper_h), .err_vwid(err_vwid_h), .err_timeout(err_timeout_h),
    .err_any(err_any_h), .err_frame(err_frame_h), .last_hper(last_hper_h)
  );

  task automatic cyc(input bit h, input bit v);
    @(negedge clk);
    hs_as = h;
    vs_as = v;
  endtask

  task automatic send_line(input int len, input int hw, input bit v);
    for (int i = 0; i < len; i++) cyc(i < hw, v);
  endtask

  task automatic send_frame(input int nlines, input int vw, input int bad, input int bad_len,
                            input int bad_hw);
    for (int l = 0; l < nlines; l++) begin
      send_line((l == bad) ? bad_len : 20, (l == bad) ? bad_hw : 4, l < vw);
    end
  endtask

  // Mid-line start followed by three lines with vsync idle: never flags.
  task automatic send_partial();
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0);
    for (int l = 0; l < 3; l++) send_line(20, 4, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hs_as = 1'b0;
    vs_as = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else n_pass++;
    n_checks++; if (frame_cnt !== 8'd0) $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
    n_checks++; if (err_any !== 1'b0) $display("FAIL rst_err_any: got %0b want 0", err_any); else n_pass++;
    n_checks++; if (last_hper !== 24'd0) $display("FAIL rst_last_hper: got %0d want 0", last_hper); else n_pass++;
    n_checks++; if (err_frame !== 8'd0) $display("FAIL rst_err_frame: got %0d want 0", err_frame); else n_pass++;
  endtask

  task automatic test_nominal();
    do_reset();
    send_partial();
    send_frame(10, 2, -1, 20, 4);
    send_frame(3, 2, -1, 20, 4);
    n_checks++; if (frame_cnt !== 8'd1) $display("FAIL nom_mid_frame_cnt: got %0d want 1", frame_cnt); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL nom_mid_done: got %0b want 0", done); else n_pass++;
    for (int l = 3; l < 10; l++) send_line(20, 4, 1'b0);
    send_frame(2, 2, -1, 20, 4);
    // A bad line after done must not disturb the frozen results.
    send_line(30, 6, 1'b0);
    send_line(20, 4, 1'b0);
    n_checks++; if (done !== 1'b1) $display("FAIL nom_done: got %0b want 1", done); else n_pass++;
    n_checks++; if (frame_cnt !== 8'd2) $display("FAIL nom_frame_cnt: got %0d want 2", frame_cnt); else n_pass++;
    n_checks++; if (err_any !== 1'b0) $display("FAIL nom_err_any: got %0b want 0", err_any); else n_pass++;
    n_checks++; if (last_hper !== 24'd20) $display("FAIL nom_last_hper: got %0d want 20", last_hper); else n_pass++;
    n_checks++; if (done_h !== 1'b1) $display("FAIL hi_done: got %0b want 1", done_h); else n_pass++;
    n_checks++; if (frame_cnt_h !== 8'd2) $display("FAIL hi_frame_cnt: got %0d want 2", frame_cnt_h); else n_pass++;
    n_checks++; if (err_any_h !== 1'b0) $display("FAIL hi_err_any: got %0b want 0", err_any_h); else n_pass++;
    n_checks++; if (last_hper_h !== 24'd20) $display("FAIL hi_last_hper: got %0d want 20", last_hper_h); else n_pass++;
  endtask

  task automatic test_hper();
    do_reset();
    send_partial();
    send_frame(10, 2, -1, 20, 4);
    send_frame(10, 2, 5, 21, 4);
    send_frame(2, 2, -1, 20, 4);
    n_checks++; if (err_hper !== 1'b1) $display("FAIL hper_flag: got %0b want 1", err_hper); else n_pass++;
    n_checks++; if (err_frame !== 8'd1) $display("FAIL hper_err_frame: got %0d want 1", err_frame); else n_pass++;
    n_checks++; if ({err_hwid, err_vper, err_vwid, err_timeout} !== 4'b0000)
      $display("FAIL hper_others: got %b want 0000", {err_hwid, err_vper, err_vwid, err_timeout});
    else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL hper_done: got %0b want 1", done); else n_pass++;
  endtask

  task automatic test_hwid();
    do_reset();
    send_partial();
    send_frame(10, 2, -1, 20, 4);
    send_frame(10, 2, 5, 20, 5);
    n_checks++; if (err_hwid !== 1'b1) $display("FAIL hwid_flag: got %0b want 1", err_hwid); else n_pass++;
    n_checks++; if (err_hper !== 1'b0) $display("FAIL hwid_hper: got %0b want 0", err_hper); else n_pass++;
  endtask

  task automatic test_vper();
    do_reset();
    send_partial();
    send_frame(10, 2, -1, 20, 4);
    send_frame(11, 2, -1, 20, 4);
    send_frame(2, 2, -1, 20, 4);
    n_checks++; if (err_vper !== 1'b1) $display("FAIL vper_flag: got %0b want 1", err_vper); else n_pass++;
    n_checks++; if (err_vwid !== 1'b0) $display("FAIL vper_vwid: got %0b want 0", err_vwid); else n_pass++;
    n_checks++; if (err_frame !== 8'd1) $display("FAIL vper_err_frame: got %0d want 1", err_frame); else n_pass++;
  endtask

  task automatic test_vwid();
    do_reset();
    send_partial();
    send_frame(10, 2, -1, 20, 4);
    send_frame(10, 3, -1, 20, 4);
    n_checks++; if (err_vwid !== 1'b1) $display("FAIL vwid_flag: got %0b want 1", err_vwid); else n_pass++;
    n_checks++; if (err_vper !== 1'b0) $display("FAIL vwid_vper: got %0b want 0", err_vper); else n_pass++;
  endtask

  // Last line's assert is sampled on the posedge after its first negedge; the flag must
  // appear 40 clocks after that sample edge and not one clock earlier.
  task automatic test_timeout();
    do_reset();
    send_partial();
    repeat (21) @(negedge clk);
    n_checks++; if (err_timeout !== 1'b0) $display("FAIL tout_early: got %0b want 0", err_timeout); else n_pass++;
    @(negedge clk);
    n_checks++; if (err_timeout !== 1'b1) $display("FAIL tout_flag: got %0b want 1", err_timeout); else n_pass++;
    n_checks++; if (err_any !== 1'b1) $display("FAIL tout_err_any: got %0b want 1", err_any); else n_pass++;
    n_checks++; if (err_frame !== 8'd0) $display("FAIL tout_err_frame: got %0d want 0", err_frame); else n_pass++;
    repeat (50) @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL tout_done: got %0b want 0", done); else n_pass++;
  endtask

  task automatic test_midframe_reset();
    do_reset();
    send_partial();
    send_frame(10, 2, -1, 20, 4);
    send_frame(2, 2, -1, 20, 4);
    send_line(20, 5, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    n_checks++; if (err_hwid !== 1'b1) $display("FAIL mrst_pre_hwid: got %0b want 1", err_hwid); else n_pass++;
    @(negedge clk);
    #1 rst = 1'b1;
    hs_as = 1'b0;
    vs_as = 1'b0;
    #1;
    n_checks++; if (err_any !== 1'b0) $display("FAIL mrst_err_any: got %0b want 0", err_any); else n_pass++;
    n_checks++; if (frame_cnt !== 8'd0) $display("FAIL mrst_frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
    n_checks++; if (last_hper !== 24'd0) $display("FAIL mrst_last_hper: got %0d want 0", last_hper); else n_pass++;
    n_checks++; if (err_frame !== 8'd0) $display("FAIL mrst_err_frame: got %0d want 0", err_frame); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0);
    for (int l = 0; l < 4; l++) send_line(20, 4, 1'b0);
    send_frame(10, 2, -1, 20, 4);
    send_frame(10, 2, -1, 20, 4);
    n_checks++; if (done !== 1'b0) $display("FAIL mrst_early_done: got %0b want 0", done); else n_pass++;
    send_frame(2, 2, -1, 20, 4);
    n_checks++; if (done !== 1'b1) $display("FAIL mrst_done: got %0b want 1", done); else n_pass++;
    n_checks++; if (frame_cnt !== 8'd2) $display("FAIL mrst_frame_cnt2: got %0d want 2", frame_cnt); else n_pass++;
    n_checks++; if (err_any !== 1'b0) $display("FAIL mrst_err_after: got %0b want 0", err_any); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_hper();
    test_hwid();
    test_vper();
    test_vwid();
    test_timeout();
    test_midframe_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
